serial_ripple_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor; the inverse operation of the team's combinational ripple-carry adder.
- Computes {bout, diff} = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, through a single full-subtractor cell.
- Start/done handshake.
- Used where area matters more than latency, and as a cross-check model against the adder path (a - b + b == a).

---
 rtl/serial_ripple_subtractor_pkg.sv | 14 +
 rtl/serial_ripple_subtractor_if.sv | 36 +++
 rtl/serial_ripple_subtractor_full_subtractor.sv | 13 +
 rtl/serial_ripple_subtractor.sv | 109 ++++++++++
 tb/tb_serial_ripple_subtractor.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor.
// FSM state encodings and the default operand width.
// No logic here; imported by the interface and the top.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_ripple_subtractor_if.sv
// Request/result bundle for serial_ripple_subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
// master drives operands and start, slave (the subtractor) drives status and result.
// Start is a level request sampled only while the subtractor is idle.
interface serial_ripple_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per cycle; SERIAL_SUB_OVF_EN adds signed ovf.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+WIDTH.
// Backpressure: start is ignored (not queued) while busy in RUN or DONE.
module serial_ripple_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = SUB_WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_ripple_subtractor_if.slave   sub_if
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             d_bit, bo_bit;

    full_subtractor u_fs (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .bi (br_q),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (sub_if.start) begin
                    sa_d    = sub_if.a;
                    sb_d    = sub_if.b;
                    br_d    = sub_if.bin;
                    sd_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sd_d  = {d_bit, sd_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = bo_bit;
                cnt_d = cnt_q + 1'b1;
                // Final step: sa_q[0]/sb_q[0] now hold the captured operand MSBs.
                if (cnt_q == CNT_LAST) begin
                    diff_d  = {d_bit, sd_q[WIDTH-1:1]};
                    bout_d  = bo_bit;
                    ovf_d   = (sa_q[0] != sb_q[0]) && (d_bit != sa_q[0]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sub_if.busy = (state_q != ST_IDLE);
    assign sub_if.done = (state_q == ST_DONE);
    assign sub_if.diff = diff_q;
    assign sub_if.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign sub_if.ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor at WIDTH=4; ovf cases under SERIAL_SUB_OVF_EN.
module tb_serial_ripple_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    serial_ripple_subtractor_if #(.WIDTH(4)) bus ();

    serial_ripple_subtractor #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .sub_if (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start; operands scrambled after acceptance to prove they were captured.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                          output logic [3:0] rd, output logic rb);
        int n;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.bin = tbin;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~ta; bus.b = ~tb_v; bus.bin = ~tbin;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1;
        end
        chk("latency", n, 4);
        rd = bus.diff;
        rb = bus.bout;
        @(negedge clk);
        chk("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        logic [3:0] rd;
        logic       rb;
        int         ref5;
        int         dones;
        int         t1, t2;
        logic [3:0] dcap;

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {27'd0, bus.busy, bus.done, bus.bout, bus.diff[1:0]}, 32'd0);
        chk("reset_diff", {28'd0, bus.diff}, 32'd0);
        rst = 1'b0;

        // 9 - 3: detailed cycle-by-cycle check
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd15;
        chk("run0_busy", {30'd0, bus.busy, bus.done}, 32'd2);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("run_busy", {30'd0, bus.busy, bus.done}, 32'd2);
            chk("run_diff_hold", {27'd0, bus.bout, bus.diff}, 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", {30'd0, bus.busy, bus.done}, 32'd3);
        chk("diff_9m3", {28'd0, bus.diff}, 32'd6);
        chk("bout_9m3", {31'd0, bus.bout}, 32'd0);
        @(negedge clk);
        chk("idle_after", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("diff_hold", {28'd0, bus.diff}, 32'd6);

        run_op(4'd3, 4'd9, 1'b0, rd, rb);
        chk("diff_3m9", {27'd0, rb, rd}, {27'd0, 1'b1, 4'b1010});
        run_op(4'd0, 4'd0, 1'b1, rd, rb);
        chk("diff_0m0m1", {27'd0, rb, rd}, {27'd0, 1'b1, 4'b1111});

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(4'(ia), 4'(ib), 1'(ic), rd, rb);
                    ref5 = (ia - ib - ic) & 31;
                    chk("exh_model", {27'd0, rb, rd}, 32'(ref5));
                    chk("exh_readd", (32'(rd) + 32'(ib) + 32'(ic)) & 32'd15, 32'(ia));
                end
            end
        end

        // start pulsed during RUN must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd7;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; dcap = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) begin dones++; dcap = bus.diff; end
        end
        chk("ignore_done_cnt", 32'(dones), 32'd1);
        chk("ignore_diff", {28'd0, dcap}, 32'd6);

        // start held high: back-to-back every WIDTH+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd2; bus.bin = 1'b0;
        t1 = -1; t2 = -1; dcap = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dcap = bus.diff;
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        bus.start = 1'b0;
        chk("b2b_period", 32'(t2 - t1), 32'd6);
        chk("b2b_diff", {28'd0, dcap}, 32'd3);
        repeat (8) @(negedge clk);

        // async reset two cycles into RUN
        bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd5; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", {27'd0, bus.busy, bus.done, bus.bout, bus.diff[1:0]}, 32'd0);
        chk("arst_diff", {28'd0, bus.diff}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("arst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        run_op(4'd12, 4'd5, 1'b0, rd, rb);
        chk("after_rst", {27'd0, rb, rd}, 32'd7);

`ifdef SERIAL_SUB_OVF_EN
        run_op(4'b0111, 4'b1000, 1'b0, rd, rb);
        chk("ovf_pos", {26'd0, bus.ovf, rb, rd}, {26'd0, 1'b1, 1'b1, 4'b1111});
        run_op(4'd5, 4'd2, 1'b0, rd, rb);
        chk("ovf_none", {26'd0, bus.ovf, rb, rd}, {26'd0, 1'b0, 1'b0, 4'd3});
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
